// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller: load-use stalls, taken-branch flush, operand forwarding.
// Optional perf counters (stall_count_o / flush_count_o) are built when HAZARD_PERF_EN is defined.
module exec_hazard_ctrl #(
  parameter int unsigned REG_BITS     = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [REG_BITS-1:0] rs1_i,
  input  logic [REG_BITS-1:0] rs2_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic [REG_BITS-1:0] id_ex_rd_i,
  input  logic                id_ex_reg_we_i,
  input  logic                id_ex_mem_read_i,
  input  logic [REG_BITS-1:0] ex_mem_rd_i,
  input  logic                ex_mem_reg_we_i,
  input  logic                ex_mem_from_alu_i,
  input  logic [REG_BITS-1:0] mem_wb_rd_i,
  input  logic                mem_wb_reg_we_i,
  input  logic                pc_we_i,
  output logic                stall_fetch_o,
  output logic                stall_decode_o,
  output logic                flush_decode_o,
  output logic                flush_execute_o,
  output logic [1:0]          fwd_a_o,
  output logic [1:0]          fwd_b_o,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]    stall_count_o,
  output logic [CNT_W-1:0]    flush_count_o,
`endif
  output logic                busy_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..15");
  end
  if (LOAD_STALL < 1 || LOAD_STALL > 15) begin : g_bad_load_stall
    $error("LOAD_STALL must be in 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  localparam int unsigned StallInitInt = (LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0;
  localparam logic [3:0]  FlushInit    = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0]  StallInit    = 4'(StallInitInt);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hz;
  logic       stall, flush_dec, flush_exe;

  assign hz = id_ex_mem_read_i & id_ex_reg_we_i &
              ((rs1_used_i & (rs1_i == id_ex_rd_i)) | (rs2_used_i & (rs2_i == id_ex_rd_i)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A taken branch wins from every state; FLUSH restarts on a new one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (pc_we_i) begin
          state_d = StFlush;
          cnt_d   = FlushInit;
        end else if (hz && (LOAD_STALL > 1)) begin
          state_d = StStall;
          cnt_d   = StallInit;
        end
      end
      StStall, StFlush: begin
        if (pc_we_i) begin
          state_d = StFlush;
          cnt_d   = FlushInit;
        end else if (cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    flush_dec = 1'b0;
    flush_exe = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!pc_we_i && hz) begin
          stall     = 1'b1;
          flush_exe = 1'b1;
        end
      end
      StStall: begin
        stall     = ~pc_we_i;
        flush_exe = 1'b1;
      end
      StFlush: begin
        flush_dec = 1'b1;
        flush_exe = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are forced low while reset is held, including the forwarding selects.
  assign stall_fetch_o   = rst_ni & stall;
  assign stall_decode_o  = rst_ni & stall;
  assign flush_decode_o  = rst_ni & flush_dec;
  assign flush_execute_o = rst_ni & flush_exe;
  assign busy_o          = rst_ni & (state_q != StRun);

  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (rst_ni) begin
      if (ex_mem_reg_we_i && ex_mem_from_alu_i && rs1_used_i && (ex_mem_rd_i == rs1_i)) begin
        fwd_a_o = 2'b01;
      end else if (mem_wb_reg_we_i && rs1_used_i && (mem_wb_rd_i == rs1_i)) begin
        fwd_a_o = 2'b10;
      end
      if (ex_mem_reg_we_i && ex_mem_from_alu_i && rs2_used_i && (ex_mem_rd_i == rs2_i)) begin
        fwd_b_o = 2'b01;
      end else if (mem_wb_reg_we_i && rs2_used_i && (mem_wb_rd_i == rs2_i)) begin
        fwd_b_o = 2'b10;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_we_i && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Bench for exec_hazard_ctrl: two instances (short and long stall/flush) against a cycle model
// built from remaining-stall / remaining-flush counts.
module tb_exec_hazard_ctrl;
  localparam int unsigned RB  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned F_A = 2;
  localparam int unsigned L_A = 1;
  localparam int unsigned F_B = 3;
  localparam int unsigned L_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [RB-1:0] rs1, rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic rs1_used, rs2_used, id_ex_reg_we, id_ex_mem_read;
  logic ex_mem_reg_we, ex_mem_from_alu, mem_wb_reg_we, pc_we;

  logic       sf [2], sd [2], fd [2], fe [2], bz [2];
  logic [1:0] fa [2], fb [2];
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] sc [2], fc [2];
`endif

  int total = 0;
  int bad   = 0;

  // Model state: cycles of stall / flush still to be shown, starting this cycle.
  int stall_left [2];
  int flush_left [2];
  int scnt [2];
  int fcnt [2];
  int flen [2] = '{F_A, F_B};
  int llen [2] = '{L_A, L_B};

  always #5 clk = ~clk;

  exec_hazard_ctrl #(.REG_BITS(RB), .FLUSH_CYCLES(F_A), .LOAD_STALL(L_A), .CNT_W(CW)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used),
    .rs2_used_i(rs2_used), .id_ex_rd_i(id_ex_rd), .id_ex_reg_we_i(id_ex_reg_we),
    .id_ex_mem_read_i(id_ex_mem_read), .ex_mem_rd_i(ex_mem_rd), .ex_mem_reg_we_i(ex_mem_reg_we),
    .ex_mem_from_alu_i(ex_mem_from_alu), .mem_wb_rd_i(mem_wb_rd), .mem_wb_reg_we_i(mem_wb_reg_we),
    .pc_we_i(pc_we), .stall_fetch_o(sf[0]), .stall_decode_o(sd[0]), .flush_decode_o(fd[0]),
    .flush_execute_o(fe[0]), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]),
`ifdef HAZARD_PERF_EN
    .stall_count_o(sc[0]), .flush_count_o(fc[0]),
`endif
    .busy_o(bz[0])
  );

  exec_hazard_ctrl #(.REG_BITS(RB), .FLUSH_CYCLES(F_B), .LOAD_STALL(L_B), .CNT_W(CW)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used),
    .rs2_used_i(rs2_used), .id_ex_rd_i(id_ex_rd), .id_ex_reg_we_i(id_ex_reg_we),
    .id_ex_mem_read_i(id_ex_mem_read), .ex_mem_rd_i(ex_mem_rd), .ex_mem_reg_we_i(ex_mem_reg_we),
    .ex_mem_from_alu_i(ex_mem_from_alu), .mem_wb_rd_i(mem_wb_rd), .mem_wb_reg_we_i(mem_wb_reg_we),
    .pc_we_i(pc_we), .stall_fetch_o(sf[1]), .stall_decode_o(sd[1]), .flush_decode_o(fd[1]),
    .flush_execute_o(fe[1]), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]),
`ifdef HAZARD_PERF_EN
    .stall_count_o(sc[1]), .flush_count_o(fc[1]),
`endif
    .busy_o(bz[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hz_now();
    return id_ex_mem_read && id_ex_reg_we &&
           ((rs1_used && rs1 == id_ex_rd) || (rs2_used && rs2 == id_ex_rd));
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [RB-1:0] rs, input logic used);
    if (!rst_n || !used) return 2'b00;
    if (ex_mem_reg_we && ex_mem_from_alu && ex_mem_rd == rs) return 2'b01;
    if (mem_wb_reg_we && mem_wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0;
      flush_left[k] = 0;
      scnt[k]       = 0;
      fcnt[k]       = 0;
    end
  endtask

  task automatic idle_inputs();
    {rs1, rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
    {rs1_used, rs2_used, id_ex_reg_we, id_ex_mem_read} = '0;
    {ex_mem_reg_we, ex_mem_from_alu, mem_wb_reg_we, pc_we} = '0;
  endtask

  task automatic rand_inputs();
    rs1 = RB'($urandom_range(0, 3));
    rs2 = RB'($urandom_range(0, 3));
    id_ex_rd  = RB'($urandom_range(0, 3));
    ex_mem_rd = RB'($urandom_range(0, 3));
    mem_wb_rd = RB'($urandom_range(0, 3));
    rs1_used = 1'($urandom);
    rs2_used = 1'($urandom);
    id_ex_reg_we = 1'($urandom);
    id_ex_mem_read = ($urandom_range(0, 2) == 0);
    ex_mem_reg_we = 1'($urandom);
    ex_mem_from_alu = 1'($urandom);
    mem_wb_reg_we = 1'($urandom);
    pc_we = ($urandom_range(0, 9) == 0);
  endtask

  // One clock: compare combinational outputs at the falling edge, then advance the model.
  task automatic step();
    bit esf, efd, efe, ebz;
    if (!rst_n) model_clear();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      esf = 0; efd = 0; efe = 0;
      if (rst_n) begin
        if (flush_left[k] > 0) begin
          efd = 1; efe = 1;
        end else if (stall_left[k] > 0) begin
          efe = 1; esf = !pc_we;
        end else if (!pc_we && hz_now()) begin
          esf = 1; efe = 1;
        end
      end
      ebz = rst_n && (flush_left[k] > 0 || stall_left[k] > 0);
      check($sformatf("stall_fetch[%0d]", k), 32'(sf[k]), 32'(esf));
      check($sformatf("stall_decode[%0d]", k), 32'(sd[k]), 32'(esf));
      check($sformatf("flush_decode[%0d]", k), 32'(fd[k]), 32'(efd));
      check($sformatf("flush_execute[%0d]", k), 32'(fe[k]), 32'(efe));
      check($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(ebz));
      check($sformatf("fwd_a[%0d]", k), 32'(fa[k]), 32'(fwd_ref(rs1, rs1_used)));
      check($sformatf("fwd_b[%0d]", k), 32'(fb[k]), 32'(fwd_ref(rs2, rs2_used)));
`ifdef HAZARD_PERF_EN
      check($sformatf("stall_count[%0d]", k), 32'(sc[k]), 32'(scnt[k]));
      check($sformatf("flush_count[%0d]", k), 32'(fc[k]), 32'(fcnt[k]));
`endif
      if (rst_n) begin
        if (esf && scnt[k] < (1 << CW) - 1) scnt[k]++;
        if (pc_we && fcnt[k] < (1 << CW) - 1) fcnt[k]++;
        if (pc_we) begin
          flush_left[k] = flen[k];
          stall_left[k] = 0;
        end else if (flush_left[k] > 0) begin
          flush_left[k]--;
        end else if (stall_left[k] > 0) begin
          stall_left[k]--;
        end else if (hz_now()) begin
          stall_left[k] = llen[k] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    idle_inputs();
    id_ex_mem_read = 1; id_ex_reg_we = 1; id_ex_rd = 3; rs1 = 3; rs1_used = 1;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    rst_n = 1'b0;
    // Reset held with random inputs: everything must read zero.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    step();

    // Load-use: 1 bubble on instance A, 3 on instance B.
    load_use();
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Taken branch.
    pc_we = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();

    // Branch arriving while instance B is stalled.
    load_use();
    step();
    idle_inputs();
    pc_we = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();

    // Flush restart, and a hazard that must be ignored during flush.
    pc_we = 1;
    step();
    pc_we = 0;
    step();
    pc_we = 1;
    step();
    load_use();
    for (int i = 0; i < 4; i++) step();
    idle_inputs();
    step();

    // Forwarding priority and the load-at-memory case.
    ex_mem_rd = 5; ex_mem_reg_we = 1; ex_mem_from_alu = 1;
    mem_wb_rd = 5; mem_wb_reg_we = 1;
    rs1 = 5; rs1_used = 1; rs2 = 7; rs2_used = 1;
    #1;
    check("fwd_a_exmem", 32'(fa[0]), 32'd1);
    check("fwd_b_none", 32'(fb[0]), 32'd0);
    step();
    ex_mem_from_alu = 0;
    #1;
    check("fwd_a_memwb", 32'(fa[0]), 32'd2);
    step();
    idle_inputs();

    // Reset in the middle of a flush and a stall abandons them.
    pc_we = 1;
    step();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    load_use();
    step();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
